// File: rtl/axi4_lite_pkg.sv
// axi4_lite_pkg: response codes, channel FSM encodings and index sizing
// shared by the AXI4-Lite register endpoint.
package axi4_lite_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic {
        W_IDLE = 1'b0,
        W_RESP = 1'b1
    } w_state_e;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } r_state_e;

    localparam int NREGS_DEF = 16;

    function automatic int idx_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    localparam int IDX_W = idx_w(NREGS_DEF);

endpackage

// File: rtl/axi4_lite_slave_wr_chan.sv
// AW/W capture in either order and B response FSM for the register endpoint.
// AXI_LITE_SLVERR_EN: out-of-range writes answer SLVERR instead of OKAY.
module axi4_lite_slave_wr_chan
    import axi4_lite_pkg::*;
#(
    parameter int DW    = 32,
    parameter int AW    = 32,
    parameter int NREGS = NREGS_DEF,
    parameter int IW    = idx_w(NREGS)
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic [AW-3:0]   awaddr_i,
    input  logic            awvalid_i,
    output logic            awready_o,
    input  logic [DW-1:0]   wdata_i,
    input  logic [DW/8-1:0] wstrb_i,
    input  logic            wvalid_i,
    output logic            wready_o,
    output logic [1:0]      bresp_o,
    output logic            bvalid_o,
    input  logic            bready_i,
    output logic            commit_o,
    output logic [IW-1:0]   idx_o,
    output logic [DW-1:0]   data_o,
    output logic [DW/8-1:0] strb_o,
    output logic            in_range_o
);

    localparam logic [AW-3:0] LIM = (AW-2)'(NREGS);

    w_state_e        state_q, state_d;
    logic            awready_q, awready_d;
    logic            wready_q, wready_d;
    logic            aw_held_q, aw_held_d;
    logic            w_held_q, w_held_d;
    logic            bvalid_q, bvalid_d;
    logic [1:0]      bresp_q, bresp_d;
    logic [AW-3:0]   wa_q, wa_d;
    logic [DW-1:0]   data_q, data_d;
    logic [DW/8-1:0] strb_q, strb_d;

    logic            aw_hs, w_hs, aw_have, w_have;
    logic [AW-3:0]   cur_wa;

    assign aw_hs   = awvalid_i & awready_q;
    assign w_hs    = wvalid_i & wready_q;
    assign aw_have = aw_held_q | aw_hs;
    assign w_have  = w_held_q | w_hs;

    // A beat arriving on the commit edge is used directly, not via its latch.
    assign cur_wa     = aw_held_q ? wa_q : awaddr_i;
    assign idx_o      = cur_wa[IW-1:0];
    assign in_range_o = cur_wa < LIM;
    assign data_o     = w_held_q ? data_q : wdata_i;
    assign strb_o     = w_held_q ? strb_q : wstrb_i;

    always_comb begin
        state_d   = state_q;
        awready_d = awready_q;
        wready_d  = wready_q;
        aw_held_d = aw_held_q;
        w_held_d  = w_held_q;
        bvalid_d  = bvalid_q;
        bresp_d   = bresp_q;
        wa_d      = wa_q;
        data_d    = data_q;
        strb_d    = strb_q;
        commit_o  = 1'b0;
        unique case (state_q)
            W_IDLE: begin
                if (aw_hs) begin
                    aw_held_d = 1'b1;
                    wa_d      = awaddr_i;
                end
                if (w_hs) begin
                    w_held_d = 1'b1;
                    data_d   = wdata_i;
                    strb_d   = wstrb_i;
                end
                if (aw_have && w_have) begin
                    commit_o  = 1'b1;
                    state_d   = W_RESP;
                    aw_held_d = 1'b0;
                    w_held_d  = 1'b0;
                    awready_d = 1'b0;
                    wready_d  = 1'b0;
                    bvalid_d  = 1'b1;
`ifdef AXI_LITE_SLVERR_EN
                    bresp_d   = in_range_o ? RESP_OKAY : RESP_SLVERR;
`else
                    bresp_d   = RESP_OKAY;
`endif
                end else begin
                    awready_d = ~aw_have;
                    wready_d  = ~w_have;
                end
            end
            W_RESP: begin
                if (bready_i) begin
                    state_d   = W_IDLE;
                    bvalid_d  = 1'b0;
                    bresp_d   = RESP_OKAY;
                    awready_d = 1'b1;
                    wready_d  = 1'b1;
                end
            end
            default: state_d = W_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= W_IDLE;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            aw_held_q <= 1'b0;
            w_held_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
            wa_q      <= '0;
            data_q    <= '0;
            strb_q    <= '0;
        end else begin
            state_q   <= state_d;
            awready_q <= awready_d;
            wready_q  <= wready_d;
            aw_held_q <= aw_held_d;
            w_held_q  <= w_held_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
            wa_q      <= wa_d;
            data_q    <= data_d;
            strb_q    <= strb_d;
        end
    end

    assign awready_o = awready_q;
    assign wready_o  = wready_q;
    assign bvalid_o  = bvalid_q;
    assign bresp_o   = bresp_q;

endmodule

// File: rtl/axi4_lite_slave_regs.sv
// AXI4-Lite register endpoint: NREGS control registers, independent read FSM.
// AXI_LITE_SLVERR_EN: out-of-range accesses answer SLVERR instead of OKAY.
module axi4_lite_slave_regs
    import axi4_lite_pkg::*;
#(
    parameter int DW    = 32,
    parameter int AW    = 32,
    parameter int NREGS = NREGS_DEF
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic [AW-1:0]      S_AXI_AWADDR,
    input  logic               S_AXI_AWVALID,
    input  logic [2:0]         S_AXI_AWPROT,
    output logic               S_AXI_AWREADY,
    input  logic [DW-1:0]      S_AXI_WDATA,
    input  logic [DW/8-1:0]    S_AXI_WSTRB,
    input  logic               S_AXI_WVALID,
    output logic               S_AXI_WREADY,
    output logic [1:0]         S_AXI_BRESP,
    output logic               S_AXI_BVALID,
    input  logic               S_AXI_BREADY,
    input  logic [AW-1:0]      S_AXI_ARADDR,
    input  logic               S_AXI_ARVALID,
    input  logic [2:0]         S_AXI_ARPROT,
    output logic               S_AXI_ARREADY,
    output logic [DW-1:0]      S_AXI_RDATA,
    output logic [1:0]         S_AXI_RRESP,
    output logic               S_AXI_RVALID,
    input  logic               S_AXI_RREADY,
    output logic [NREGS*DW-1:0] reg_out,
    output logic [NREGS-1:0]   wr_strobe
);

    localparam int IW = idx_w(NREGS);
    localparam logic [AW-3:0] LIM = (AW-2)'(NREGS);

    logic            wr_commit, wr_in_range;
    logic [IW-1:0]   wr_idx;
    logic [DW-1:0]   wr_data;
    logic [DW/8-1:0] wr_strb;

    axi4_lite_slave_wr_chan #(
        .DW    (DW),
        .AW    (AW),
        .NREGS (NREGS),
        .IW    (IW)
    ) u_wr_chan (
        .clk_i      (clk),
        .rst_ni     (resetn),
        .awaddr_i   (S_AXI_AWADDR[AW-1:2]),
        .awvalid_i  (S_AXI_AWVALID),
        .awready_o  (S_AXI_AWREADY),
        .wdata_i    (S_AXI_WDATA),
        .wstrb_i    (S_AXI_WSTRB),
        .wvalid_i   (S_AXI_WVALID),
        .wready_o   (S_AXI_WREADY),
        .bresp_o    (S_AXI_BRESP),
        .bvalid_o   (S_AXI_BVALID),
        .bready_i   (S_AXI_BREADY),
        .commit_o   (wr_commit),
        .idx_o      (wr_idx),
        .data_o     (wr_data),
        .strb_o     (wr_strb),
        .in_range_o (wr_in_range)
    );

    logic [DW-1:0]    regs_q [NREGS];
    logic [DW-1:0]    regs_d [NREGS];
    logic [NREGS-1:0] wr_strobe_q, wr_strobe_d;

    always_comb begin
        regs_d      = regs_q;
        wr_strobe_d = '0;
        if (wr_commit && wr_in_range) begin
            for (int b = 0; b < DW/8; b++) begin
                if (wr_strb[b]) regs_d[wr_idx][8*b +: 8] = wr_data[8*b +: 8];
            end
            wr_strobe_d[wr_idx] = 1'b1;
        end
    end

    r_state_e      r_state_q, r_state_d;
    logic          arready_q, arready_d;
    logic          rvalid_q, rvalid_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic [1:0]    rresp_q, rresp_d;
    logic [IW-1:0] rd_idx;
    logic          rd_in_range;

    assign rd_idx      = S_AXI_ARADDR[IW+1:2];
    assign rd_in_range = S_AXI_ARADDR[AW-1:2] < LIM;

    // Reads sample regs_q, so a write committing on the same edge is unseen.
    always_comb begin
        r_state_d = r_state_q;
        arready_d = arready_q;
        rvalid_d  = rvalid_q;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;
        unique case (r_state_q)
            R_IDLE: begin
                arready_d = 1'b1;
                if (S_AXI_ARVALID && arready_q) begin
                    r_state_d = R_DATA;
                    arready_d = 1'b0;
                    rvalid_d  = 1'b1;
                    rdata_d   = rd_in_range ? regs_q[rd_idx] : '0;
`ifdef AXI_LITE_SLVERR_EN
                    rresp_d   = rd_in_range ? RESP_OKAY : RESP_SLVERR;
`else
                    rresp_d   = RESP_OKAY;
`endif
                end
            end
            R_DATA: begin
                if (S_AXI_RREADY) begin
                    r_state_d = R_IDLE;
                    rvalid_d  = 1'b0;
                    arready_d = 1'b1;
                end
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            regs_q      <= '{default: '0};
            wr_strobe_q <= '0;
            r_state_q   <= R_IDLE;
            arready_q   <= 1'b0;
            rvalid_q    <= 1'b0;
            rdata_q     <= '0;
            rresp_q     <= RESP_OKAY;
        end else begin
            regs_q      <= regs_d;
            wr_strobe_q <= wr_strobe_d;
            r_state_q   <= r_state_d;
            arready_q   <= arready_d;
            rvalid_q    <= rvalid_d;
            rdata_q     <= rdata_d;
            rresp_q     <= rresp_d;
        end
    end

    for (genvar i = 0; i < NREGS; i++) begin : g_out
        assign reg_out[i*DW +: DW] = regs_q[i];
    end

    assign wr_strobe     = wr_strobe_q;
    assign S_AXI_ARREADY = arready_q;
    assign S_AXI_RVALID  = rvalid_q;
    assign S_AXI_RDATA   = rdata_q;
    assign S_AXI_RRESP   = rresp_q;

    logic unused_bits;
    assign unused_bits = ^{S_AXI_AWPROT, S_AXI_ARPROT,
                           S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

endmodule

// File: tb/tb_axi4_lite_slave_regs.sv
// Directed plus randomized bench for axi4_lite_slave_regs against an
// array-based register model; honours AXI_LITE_SLVERR_EN when defined.
module tb_axi4_lite_slave_regs;

    localparam int DW    = 32;
    localparam int AW    = 32;
    localparam int NREGS = 16;

    logic               clk = 1'b0;
    logic               resetn = 1'b0;
    logic [AW-1:0]      S_AXI_AWADDR = '0;
    logic               S_AXI_AWVALID = 1'b0;
    logic [2:0]         S_AXI_AWPROT = '0;
    logic               S_AXI_AWREADY;
    logic [DW-1:0]      S_AXI_WDATA = '0;
    logic [DW/8-1:0]    S_AXI_WSTRB = '0;
    logic               S_AXI_WVALID = 1'b0;
    logic               S_AXI_WREADY;
    logic [1:0]         S_AXI_BRESP;
    logic               S_AXI_BVALID;
    logic               S_AXI_BREADY = 1'b0;
    logic [AW-1:0]      S_AXI_ARADDR = '0;
    logic               S_AXI_ARVALID = 1'b0;
    logic [2:0]         S_AXI_ARPROT = '0;
    logic               S_AXI_ARREADY;
    logic [DW-1:0]      S_AXI_RDATA;
    logic [1:0]         S_AXI_RRESP;
    logic               S_AXI_RVALID;
    logic               S_AXI_RREADY = 1'b0;
    logic [NREGS*DW-1:0] reg_out;
    logic [NREGS-1:0]   wr_strobe;

    always #5 clk = ~clk;

    axi4_lite_slave_regs #(.DW(DW), .AW(AW), .NREGS(NREGS)) dut (
        .clk           (clk),
        .resetn        (resetn),
        .S_AXI_AWADDR  (S_AXI_AWADDR),
        .S_AXI_AWVALID (S_AXI_AWVALID),
        .S_AXI_AWPROT  (S_AXI_AWPROT),
        .S_AXI_AWREADY (S_AXI_AWREADY),
        .S_AXI_WDATA   (S_AXI_WDATA),
        .S_AXI_WSTRB   (S_AXI_WSTRB),
        .S_AXI_WVALID  (S_AXI_WVALID),
        .S_AXI_WREADY  (S_AXI_WREADY),
        .S_AXI_BRESP   (S_AXI_BRESP),
        .S_AXI_BVALID  (S_AXI_BVALID),
        .S_AXI_BREADY  (S_AXI_BREADY),
        .S_AXI_ARADDR  (S_AXI_ARADDR),
        .S_AXI_ARVALID (S_AXI_ARVALID),
        .S_AXI_ARPROT  (S_AXI_ARPROT),
        .S_AXI_ARREADY (S_AXI_ARREADY),
        .S_AXI_RDATA   (S_AXI_RDATA),
        .S_AXI_RRESP   (S_AXI_RRESP),
        .S_AXI_RVALID  (S_AXI_RVALID),
        .S_AXI_RREADY  (S_AXI_RREADY),
        .reg_out       (reg_out),
        .wr_strobe     (wr_strobe)
    );

    logic [31:0] model [NREGS];
    int vectors = 0;
    int miscompares = 0;

    function automatic logic [NREGS*DW-1:0] model_flat();
        logic [NREGS*DW-1:0] f;
        for (int i = 0; i < NREGS; i++) f[i*DW +: DW] = model[i];
        return f;
    endfunction

    function automatic logic in_rng(input logic [31:0] a);
        return (a >> 2) < NREGS;
    endfunction

    function automatic logic [1:0] resp_for(input logic [31:0] a);
`ifdef AXI_LITE_SLVERR_EN
        return in_rng(a) ? 2'b00 : 2'b10;
`else
        return 2'b00;
`endif
    endfunction

    function automatic void model_write(input logic [31:0] a, d,
                                        input logic [3:0] s);
        int w;
        if (!in_rng(a)) return;
        w = int'(a >> 2);
        for (int b = 0; b < 4; b++)
            if (s[b]) model[w][8*b +: 8] = d[8*b +: 8];
    endfunction

    function automatic void model_clear();
        for (int i = 0; i < NREGS; i++) model[i] = '0;
    endfunction

    task automatic chk(input string tag, input logic [511:0] obs,
                       input logic [511:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [31:0] a, d, input logic [3:0] s,
                            input int w_lead, input int bwait);
        int n;
        logic awf, wf, aw_done, w_done;
        logic [NREGS-1:0] exp_stb;
        logic [1:0] er;
        aw_done = 1'b0;
        w_done  = 1'b0;
        n = 0;
        S_AXI_WDATA  = d;
        S_AXI_WSTRB  = s;
        S_AXI_WVALID = 1'b1;
        while ((!aw_done || !w_done) && n < 50) begin
            if (n == w_lead) begin
                S_AXI_AWADDR  = a;
                S_AXI_AWVALID = 1'b1;
            end
            awf = S_AXI_AWVALID && S_AXI_AWREADY;
            wf  = S_AXI_WVALID && S_AXI_WREADY;
            step();
            n++;
            if (awf) begin S_AXI_AWVALID = 1'b0; aw_done = 1'b1; end
            if (wf)  begin S_AXI_WVALID  = 1'b0; w_done  = 1'b1; end
        end
        S_AXI_AWVALID = 1'b0;
        S_AXI_WVALID  = 1'b0;
        chk("aw_w_handshake", {aw_done, w_done}, 2'b11);
        chk("b_latency", n, w_lead + 1);
        er = resp_for(a);
        exp_stb = '0;
        if (in_rng(a)) exp_stb[a[5:2]] = 1'b1;
        model_write(a, d, s);
        chk("b_valid_resp", {S_AXI_BVALID, S_AXI_BRESP}, {1'b1, er});
        chk("wr_strobe", wr_strobe, exp_stb);
        chk("reg_out_wr", reg_out, model_flat());
        for (int i = 0; i < bwait; i++) begin
            step();
            chk("b_hold", {S_AXI_BVALID, S_AXI_BRESP, S_AXI_AWREADY,
                           S_AXI_WREADY, wr_strobe},
                {1'b1, er, 1'b0, 1'b0, {NREGS{1'b0}}});
        end
        S_AXI_BREADY = 1'b1;
        step();
        S_AXI_BREADY = 1'b0;
        chk("b_done", {S_AXI_BVALID, S_AXI_AWREADY, S_AXI_WREADY, wr_strobe},
            {1'b0, 1'b1, 1'b1, {NREGS{1'b0}}});
    endtask

    task automatic do_read(input logic [31:0] a, input int rwait);
        int n;
        logic arf, fired;
        logic [31:0] ed;
        n = 0;
        fired = 1'b0;
        S_AXI_ARADDR  = a;
        S_AXI_ARVALID = 1'b1;
        while (!fired && n < 50) begin
            arf = S_AXI_ARVALID && S_AXI_ARREADY;
            step();
            n++;
            if (arf) begin S_AXI_ARVALID = 1'b0; fired = 1'b1; end
        end
        S_AXI_ARVALID = 1'b0;
        chk("ar_handshake", {fired, n}, {1'b1, 32'd1});
        ed = in_rng(a) ? model[a[5:2]] : 32'h0;
        chk("r_data", {S_AXI_RVALID, S_AXI_RRESP, S_AXI_RDATA},
            {1'b1, resp_for(a), ed});
        for (int i = 0; i < rwait; i++) begin
            step();
            chk("r_hold", {S_AXI_RVALID, S_AXI_ARREADY, S_AXI_RRESP, S_AXI_RDATA},
                {1'b1, 1'b0, resp_for(a), ed});
        end
        S_AXI_RREADY = 1'b1;
        step();
        S_AXI_RREADY = 1'b0;
        chk("r_done", {S_AXI_RVALID, S_AXI_ARREADY}, 2'b01);
    endtask

    initial begin
        logic [31:0] a, d;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_hs", {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY,
                       S_AXI_BVALID, S_AXI_RVALID}, 5'b0);
        chk("rst_resp", {S_AXI_BRESP, S_AXI_RRESP, S_AXI_RDATA}, '0);
        chk("rst_regs", {reg_out, wr_strobe}, '0);
        resetn = 1'b1;
        #2;
        chk("ready_low_pre_edge", {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}, 3'b000);
        step();
        chk("ready_after_rst", {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}, 3'b111);

        do_write(32'h04, 32'hDEADBEEF, 4'hF, 0, 0);
        chk("reg1_deadbeef", reg_out[63:32], 32'hDEADBEEF);

        do_write(32'h08, 32'h12345678, 4'hF, 3, 0);
        do_write(32'h08, 32'h0000AA00, 4'h2, 0, 0);
        chk("reg2_merge", reg_out[95:64], 32'h1234AA78);

        do_write(32'h0C, 32'h0BAD0BAD, 4'hF, 1, 5);
        do_read(32'h04, 4);

        do_write(32'h00, 32'h00000011, 4'hF, 0, 0);
        S_AXI_AWADDR  = 32'h0;
        S_AXI_WDATA   = 32'h55;
        S_AXI_WSTRB   = 4'hF;
        S_AXI_ARADDR  = 32'h0;
        S_AXI_AWVALID = 1'b1;
        S_AXI_WVALID  = 1'b1;
        S_AXI_ARVALID = 1'b1;
        chk("same_edge_ready", {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}, 3'b111);
        step();
        S_AXI_AWVALID = 1'b0;
        S_AXI_WVALID  = 1'b0;
        S_AXI_ARVALID = 1'b0;
        chk("same_edge_rdata", {S_AXI_RVALID, S_AXI_RDATA}, {1'b1, 32'h11});
        chk("same_edge_reg0", {S_AXI_BVALID, reg_out[31:0]}, {1'b1, 32'h55});
        model[0] = 32'h55;
        S_AXI_BREADY = 1'b1;
        S_AXI_RREADY = 1'b1;
        step();
        S_AXI_BREADY = 1'b0;
        S_AXI_RREADY = 1'b0;
        chk("same_edge_done", {S_AXI_BVALID, S_AXI_RVALID}, 2'b00);

        do_write(32'h40, 32'hFFFFFFFF, 4'hF, 0, 0);
        do_read(32'h40, 0);
        do_write(32'h14, 32'hFFFFFFFF, 4'h0, 0, 0);

        for (int it = 0; it < 40; it++) begin
            a = ($urandom_range(0, 23) << 2) | $urandom_range(0, 3);
            if ($urandom_range(0, 1) == 1) begin
                d = $urandom;
                do_write(a, d, 4'($urandom_range(0, 15)),
                         $urandom_range(0, 2), $urandom_range(0, 2));
            end else begin
                do_read(a, $urandom_range(0, 2));
            end
        end

        S_AXI_AWADDR  = 32'h0C;
        S_AXI_WDATA   = 32'hCAFE0001;
        S_AXI_WSTRB   = 4'hF;
        S_AXI_AWVALID = 1'b1;
        S_AXI_WVALID  = 1'b1;
        step();
        S_AXI_AWVALID = 1'b0;
        S_AXI_WVALID  = 1'b0;
        chk("pre_rst_bvalid", S_AXI_BVALID, 1'b1);
        #2 resetn = 1'b0;
        #1;
        chk("rst_async_hs", {S_AXI_BVALID, S_AXI_AWREADY, S_AXI_WREADY,
                             S_AXI_ARREADY, S_AXI_RVALID}, 5'b0);
        chk("rst_async_regs", {reg_out, wr_strobe}, '0);
        model_clear();
        @(posedge clk);
        #1;
        resetn = 1'b1;
        step();
        do_write(32'h0C, 32'hA5A55A5A, 4'hF, 0, 1);
        do_read(32'h0C, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/axi4_lite_slave_regs.md
Name: axi4_lite_slave_regs

Overview:
AXI4-Lite slave that terminates a master port and exposes a bank of NREGS read/write control registers to fabric logic.
Write and read channels are serviced by independent FSMs, so concurrent traffic is supported.
It sits under the PCIe/host AXI-Lite interconnect as the standard register endpoint for capture-path control.

Parameters:
DW, 32, data width; only 32 supported
AW, 32, address width
NREGS, 16, number of 32-bit registers; power of 2, 2..256

Ports:
clk  input  1  clock
resetn  input  1  asynchronous active-low reset
S_AXI_AWADDR  input  AW  write address
S_AXI_AWVALID  input  1  write address valid
S_AXI_AWPROT  input  3  ignored
S_AXI_AWREADY  output  1  write address ready
S_AXI_WDATA  input  DW  write data
S_AXI_WSTRB  input  DW/8  byte strobes
S_AXI_WVALID  input  1  write data valid
S_AXI_WREADY  output  1  write data ready
S_AXI_BRESP  output  2  write response
S_AXI_BVALID  output  1  write response valid
S_AXI_BREADY  input  1  write response ready
S_AXI_ARADDR  input  AW  read address
S_AXI_ARVALID  input  1  read address valid
S_AXI_ARPROT  input  3  ignored
S_AXI_ARREADY  output  1  read address ready
S_AXI_RDATA  output  DW  read data
S_AXI_RRESP  output  2  read response
S_AXI_RVALID  output  1  read data valid
S_AXI_RREADY  input  1  read data ready
reg_out  output  NREGS*DW  register contents; reg i at [i*DW +: DW]
wr_strobe  output  NREGS  one-cycle pulse on the edge where reg i is updated

Behaviour:
- Reset (async, resetn=0): all registers=0; AWREADY, WREADY, ARREADY, BVALID, RVALID, wr_strobe = 0; RDATA=0; BRESP=RRESP=0. Ready signals rise on the first clk edge after resetn deasserts.
- Reset mid-transaction aborts it silently. No response is issued, and any partially captured AW/W is discarded.
- Decode: index = addr[log2(NREGS)+1:2]. The address is in range iff addr[AW-1:2] < NREGS. addr[1:0] is ignored.
- Write FSM states:
  - W_IDLE: AWREADY=1 until AW is captured; WREADY=1 until W is captured. AW and W are accepted in either order or in the same cycle.
  - On the edge where both are held, move to W_RESP. On that same edge: commit the data byte-wise per WSTRB (lanes with strobe=0 are unchanged), pulse wr_strobe[index], and set BVALID=1.
  - AW and W on the same cycle give BVALID exactly 1 cycle later.
  - W_RESP: AWREADY=WREADY=0. BVALID is held, and BRESP held stable, until BREADY=1. Then return to W_IDLE with both readys=1 on the next cycle.
  - An out-of-range write changes no register and gives no wr_strobe; BRESP=OKAY.
  - WSTRB=0 gives OKAY with no change, but wr_strobe still pulses.
- Read FSM states:
  - R_IDLE: ARREADY=1. On the AR handshake edge, latch RDATA = reg[index] (0 if out of range), set RVALID=1, ARREADY=0, and go to R_DATA. Latency is 1 cycle.
  - R_DATA: RDATA and RVALID are held until RREADY=1. Then return to R_IDLE.
- Simultaneous read and write to the same register: RDATA takes the value before the edge, so a write committing on the same edge is not visible to that read.
- Throughput: one write per 2 cycles and one read per 2 cycles maximum.

Optional Feature:
AXI_LITE_SLVERR_EN
- Defined: an out-of-range write gives BRESP=2'b10 (SLVERR); an out-of-range read gives RRESP=2'b10 and RDATA=0.
- Undefined: all responses are OKAY (2'b00).
- Register side effects are identical in both builds.

Decomposition:
- Package axi4_lite_pkg holds:
  - RESP_OKAY=2'b00 and RESP_SLVERR=2'b10
  - write FSM encodings W_IDLE, W_RESP
  - read FSM encodings R_IDLE, R_DATA
  - a clog2-derived index-width constant
- Sub-module axi4_lite_slave_wr_chan contains the AW/W capture and B response FSM. It outputs commit, index, data, strb and in_range.
- The register bank and read FSM stay in the top module.

Test Plan:
- Reset release, then write 0xDEADBEEF to 0x04 with AW and W on the same cycle, WSTRB=0xF -> BVALID one cycle later, BRESP=0, reg_out[63:32]=0xDEADBEEF, wr_strobe[1] pulses once.
- W presented 3 cycles before AW, data 0x12345678 to 0x08, then WSTRB=0x2 with data 0x0000AA00 -> reg2=0x1234AA78.
- BREADY held low 5 cycles -> BVALID and BRESP stable, AWREADY=WREADY=0 throughout. Read 0x04 with RREADY low 4 cycles -> RDATA=0xDEADBEEF stable.
- Write 0x55 and read of the same register (0x00) on the same edge, old value 0x11 -> RDATA=0x11, then reg0=0x55.
- Out-of-range 0x40 write 0xFFFFFFFF and read (NREGS=16) -> no register changes, no wr_strobe, RDATA=0. With AXI_LITE_SLVERR_EN, BRESP=RRESP=2'b10; without it, 2'b00.
- resetn pulsed low while in W_RESP with BVALID=1 -> BVALID=0 asynchronously, all registers=0; the next write completes normally.
